core_ctrl: RTL and testbench
============================

Name: core_ctrl

Overview:
- Run-control and program-load controller sitting between a host command interface and the single-cycle core.
- Streams instruction words into instruction memory and holds the core's PC at 0 via core_start.
- Gates instruction execution with core_en, supporting run, single-step, halt and a single PC breakpoint.
- Maintains a saturating count of executed instructions for debug and performance readout.

Parameters:
IW, 8, instruction width in bits
IMW, 4, instruction-memory address width (depth 2^IMW)
CW, 16, executed-instruction counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  controller can accept command this cycle
cmd_op  input  2  00 RUN, 01 STEP, 10 HALT, 11 LOAD
cmd_data  input  IW  LOAD: word count N (0 means 2^IMW); during LOAD state: instruction word
pc  input  IMW  current core PC
bp_en  input  1  breakpoint enable
bp_addr  input  IMW  breakpoint PC
core_en  output  1  core executes/commits one instruction this cycle
core_start  output  1  forces core PC to 0
im_we  output  1  instruction-memory write enable
im_waddr  output  IMW  instruction-memory write address
im_wdata  output  IW  instruction-memory write data
state  output  2  00 HALT, 01 LOAD, 10 RUN, 11 STEP
bp_hit  output  1  one-cycle pulse on breakpoint stop
icount  output  CW  executed-instruction count

Behaviour:
Handshake and reset:
- A command is accepted on a cycle where cmd_valid && cmd_ready.
- Reset (rst_n low at edge) sets state=HALT, icount=0, core_start=1, im_we=0, bp_hit=0, load counters=0.
- core_start falls on the first edge with rst_n high.
- Reset mid-LOAD or mid-RUN aborts immediately with the same reset values; partially written IM contents are left as-is.

cmd_ready:
- 1 in HALT, LOAD and RUN.
- 0 in STEP and during reset.

HALT:
- RUN goes to RUN and sets the skip_bp flag.
- STEP goes to STEP.
- LOAD latches N into remaining, clears waddr to 0, goes to LOAD.
- HALT is a no-op.

LOAD:
- Every accepted beat, regardless of cmd_op, is data.
- On the next edge: im_we=1, im_waddr=waddr, im_wdata=cmd_data; waddr+1 (wraps mod 2^IMW); remaining-1.
- After the beat that takes remaining to 0: state goes to HALT and core_start pulses high for exactly one cycle; icount clears.
- im_we is registered and is 0 on cycles with no accepted beat.
- N=0 loads 2^IMW words; the remaining counter is IMW+1 bits.

RUN:
- core_en = !(bp_en && pc==bp_addr && !skip_bp) (combinational).
- skip_bp clears after the first core_en cycle.
- Breakpoint match with skip_bp=0: core_en=0, next state HALT, bp_hit=1 on the next cycle for exactly one cycle. The matching instruction is not executed.
- Accepted HALT: next state HALT; core_en is still as computed this cycle (the instruction issues).
- Accepted RUN/STEP/LOAD are accepted and dropped.
- Breakpoint and HALT command in the same cycle: go to HALT with no instruction executed, and bp_hit pulses.

STEP:
- Lasts exactly one cycle: core_en=1 (the breakpoint is ignored), then HALT.

core_en:
- 0 in HALT, LOAD and reset, and whenever core_start=1.

icount:
- Increments by 1 on every cycle with core_en=1.
- Saturates at 2^CW-1 (no wrap).
- Cleared by reset and by the LOAD-completion core_start.

state:
- The registered state encoding listed in Ports.

Test Plan:
- Reset, then LOAD N=3 with words 0x11, 0x22, 0x33 sent back-to-back -> im_we high 3 cycles at addresses 0, 1, 2 with matching data; core_start pulses one cycle after the third beat; state returns to 00; icount=0.
- LOAD N=0 streaming 16 words with cmd_valid toggling every other cycle -> exactly 16 writes at addresses 0..15, no write on idle cycles, then HALT.
- From HALT, three STEP commands -> exactly three single-cycle core_en pulses; icount=3; cmd_ready=0 during each STEP cycle.
- bp_en=1, bp_addr=5, RUN with pc advancing 0,1,.. -> core_en for pc 0..4, core_en=0 at pc=5, bp_hit one pulse, state HALT, icount=5. A second RUN at pc=5 executes pc 5 (skip_bp) and continues.
- RUN, HALT accepted at pc=2, then reset asserted mid-run on a later RUN -> first: pc 2 executes, state HALT next cycle. Second: state 00, icount 0, core_start 1 during reset.
- CW=4 override, RUN for 20 cycles with bp_en=0 -> icount saturates at 15.

Source files
------------

// File: rtl/core_ctrl.sv
// Run-control and program-load controller between the host command port and
// the single-cycle core: streams instruction words into instruction memory,
// gates execution (run / step / halt / PC breakpoint) and counts executed
// instructions with a saturating counter.
module core_ctrl #(
   parameter int IW  = 8,
   parameter int IMW = 4,
   parameter int CW  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [1:0]     cmd_op,
   input  logic [IW-1:0]  cmd_data,
   input  logic [IMW-1:0] pc,
   input  logic           bp_en,
   input  logic [IMW-1:0] bp_addr,
   output logic           core_en,
   output logic           core_start,
   output logic           im_we,
   output logic [IMW-1:0] im_waddr,
   output logic [IW-1:0]  im_wdata,
   output logic [1:0]     state,
   output logic           bp_hit,
   output logic [CW-1:0]  icount
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_STEP = 2'b11
   } state_t;

   localparam logic [1:0] OP_RUN  = 2'b00;
   localparam logic [1:0] OP_STEP = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   // A word count of zero means a full memory image.
   localparam logic [IMW:0] FULL_LOAD = {1'b1, {IMW{1'b0}}};

   state_t         state_q, state_d;
   logic [IMW:0]   rem_q, rem_d;
   logic [IMW-1:0] waddr_q, waddr_d;
   logic           skip_q, skip_d;
   logic           load_done;
   logic           accept;
   logic           bp_match;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CW'(1);
   endfunction

   assign cmd_ready = rst_n && (state_q != S_STEP);
   assign accept    = cmd_valid && cmd_ready;
   // skip_bp lets a RUN resume from the very PC it stopped on.
   assign bp_match  = bp_en && (pc == bp_addr) && !skip_q;
   assign state     = state_q;

   // Execution gate: never while reset or core_start holds the PC at 0.
   always_comb begin
      core_en = 1'b0;
      if (rst_n && !core_start) begin
         case (state_q)
            S_RUN:   core_en = !bp_match;
            S_STEP:  core_en = 1'b1;
            default: core_en = 1'b0;
         endcase
      end
   end

   // Next-state logic for run control and the load stream counters.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      waddr_d   = waddr_q;
      skip_d    = skip_q;
      load_done = 1'b0;
      if (core_en && state_q == S_RUN) begin
         skip_d = 1'b0;
      end
      case (state_q)
         S_HALT: begin
            if (accept) begin
               case (cmd_op)
                  OP_RUN: begin
                     state_d = S_RUN;
                     skip_d  = 1'b1;
                  end
                  OP_STEP: state_d = S_STEP;
                  OP_LOAD: begin
                     state_d = S_LOAD;
                     rem_d   = (cmd_data == '0) ? FULL_LOAD : (IMW+1)'(cmd_data);
                     waddr_d = '0;
                  end
                  default: state_d = S_HALT;
               endcase
            end
         end
         S_LOAD: begin
            // Every accepted beat is an instruction word, whatever cmd_op says.
            if (accept) begin
               rem_d   = rem_q - (IMW+1)'(1);
               waddr_d = waddr_q + IMW'(1);
               if (rem_q == (IMW+1)'(1)) begin
                  state_d   = S_HALT;
                  load_done = 1'b1;
               end
            end
         end
         S_RUN: begin
            // A breakpoint wins over a simultaneous HALT; other commands are dropped.
            if (bp_match) begin
               state_d = S_HALT;
            end else if (accept && cmd_op == OP_HALT) begin
               state_d = S_HALT;
            end
         end
         default: state_d = S_HALT;
      endcase
   end

   // Control registers: state, counters, pulses and instruction count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_HALT;
         rem_q      <= '0;
         waddr_q    <= '0;
         skip_q     <= 1'b0;
         core_start <= 1'b1;
         im_we      <= 1'b0;
         bp_hit     <= 1'b0;
         icount     <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         waddr_q    <= waddr_d;
         skip_q     <= skip_d;
         core_start <= load_done;
         im_we      <= (state_q == S_LOAD) && accept;
         bp_hit     <= (state_q == S_RUN) && bp_match;
         if (load_done) begin
            icount <= '0;
         end else if (core_en) begin
            icount <= sat_inc(icount);
         end
      end
   end

   // Write address/data path; only meaningful while im_we is high.
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && accept) begin
         im_waddr <= waddr_q;
         im_wdata <= cmd_data;
      end
   end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the run-control rules.
module tb_core_ctrl;

   localparam int IW  = 8;
   localparam int IMW = 4;
   localparam int CW  = 16;
   localparam int DEPTH = 1 << IMW;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           cmd_valid;
   logic [1:0]     cmd_op;
   logic [IW-1:0]  cmd_data;
   logic [IMW-1:0] pc;
   logic           bp_en;
   logic [IMW-1:0] bp_addr;

   logic           cmd_ready, core_en, core_start, im_we, bp_hit;
   logic [IMW-1:0] im_waddr;
   logic [IW-1:0]  im_wdata;
   logic [1:0]     state;
   logic [CW-1:0]  icount;

   logic           s_cmd_ready, s_core_en, s_core_start, s_im_we, s_bp_hit;
   logic [IMW-1:0] s_im_waddr;
   logic [IW-1:0]  s_im_wdata;
   logic [1:0]     s_state;
   logic [3:0]     s_icount;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: mode 0 HALT, 1 LOAD, 2 RUN, 3 STEP.
   int m_state, m_rem, m_waddr, m_wa, m_wd, m_cnt, m_cnt4, pc_q;
   bit m_skip, m_cs, m_we, m_bph;
   int bp_cnt, we_cnt;

   always #5 clk = ~clk;

   core_ctrl #(.IW(IW), .IMW(IMW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
      .core_en(core_en), .core_start(core_start), .im_we(im_we), .im_waddr(im_waddr),
      .im_wdata(im_wdata), .state(state), .bp_hit(bp_hit), .icount(icount)
   );

   core_ctrl #(.IW(IW), .IMW(IMW), .CW(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
      .core_en(s_core_en), .core_start(s_core_start), .im_we(s_im_we), .im_waddr(s_im_waddr),
      .im_wdata(s_im_wdata), .state(s_state), .bp_hit(s_bp_hit), .icount(s_icount)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return rst_n && (m_state != 3);
   endfunction

   function automatic bit m_en();
      if (!rst_n || m_cs) return 1'b0;
      if (m_state == 2) return !(bp_en && pc == bp_addr && !m_skip);
      if (m_state == 3) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input bit en, input bit rdy);
      bit acc, stop;
      if (!rst_n) begin
         m_state = 0; m_rem = 0; m_waddr = 0; m_skip = 0; m_cs = 1;
         m_we = 0; m_bph = 0; m_cnt = 0; m_cnt4 = 0; pc_q = 0;
         return;
      end
      acc  = cmd_valid && rdy;
      stop = (m_state == 2) && bp_en && (pc == bp_addr) && !m_skip;
      m_we = 0; m_bph = 0; m_cs = 0;
      if (en) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt4 < 15) m_cnt4++;
         pc_q = (pc_q + 1) % DEPTH;
         if (m_state == 2) m_skip = 0;
      end
      case (m_state)
         0: if (acc) begin
               if (cmd_op == 2'b00) begin m_state = 2; m_skip = 1; end
               else if (cmd_op == 2'b01) m_state = 3;
               else if (cmd_op == 2'b11) begin
                  m_state = 1; m_waddr = 0;
                  m_rem = (cmd_data == 0) ? DEPTH : int'(cmd_data);
               end
            end
         1: if (acc) begin
               m_we = 1; m_wa = m_waddr; m_wd = int'(cmd_data);
               m_waddr = (m_waddr + 1) % DEPTH;
               m_rem--;
               if (m_rem == 0) begin
                  m_state = 0; m_cs = 1; m_cnt = 0; m_cnt4 = 0;
               end
            end
         2: if (stop) begin
               m_state = 0; m_bph = 1;
            end else if (acc && cmd_op == 2'b10) m_state = 0;
         default: m_state = 0;
      endcase
      if (m_cs) pc_q = 0;
   endtask

   // One clock: check combinational outputs, clock, advance model, check registers.
   task automatic tick();
      bit e_en, e_rdy;
      pc = pc_q[IMW-1:0];
      #1;
      e_en  = m_en();
      e_rdy = m_ready();
      chk("core_en", core_en, e_en);
      chk("cmd_ready", cmd_ready, e_rdy);
      @(posedge clk);
      model_step(e_en, e_rdy);
      #1;
      if (bp_hit) bp_cnt++;
      if (im_we) we_cnt++;
      chk("state", state, m_state);
      chk("core_start", core_start, m_cs);
      chk("im_we", im_we, m_we);
      chk("bp_hit", bp_hit, m_bph);
      chk("icount", icount, m_cnt);
      chk("icount_cw4", s_icount, m_cnt4);
      if (m_we) begin
         chk("im_waddr", im_waddr, m_wa);
         chk("im_wdata", im_wdata, m_wd);
      end
   endtask

   task automatic drive(input bit v, input logic [1:0] op, input logic [IW-1:0] d);
      cmd_valid = v;
      cmd_op    = op;
      cmd_data  = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 2'b00, '0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [IW-1:0] words [3];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      bp_en = 0; bp_addr = 0; pc = 0; pc_q = 0;
      m_state = 0; m_cs = 1; bp_cnt = 0; we_cnt = 0;

      // Reset state
      do_reset();
      chk("rst_state", state, 0);
      chk("rst_icount", icount, 0);
      chk("rst_core_start", core_start, 1);

      // LOAD N=3, back-to-back beats (cmd_op on data beats is ignored)
      drive(1, 2'b11, 8'd3);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'(i), words[i]);
         tick();
      end
      chk("load3_we", im_we, 1);
      chk("load3_addr", im_waddr, 2);
      chk("load3_data", im_wdata, 8'h33);
      chk("load3_start", core_start, 1);
      chk("load3_state", state, 0);
      drive(0, 2'b00, '0);
      tick();
      chk("load3_start_fall", core_start, 0);
      chk("load3_icount", icount, 0);

      // LOAD N=0 with valid toggling every other cycle
      drive(1, 2'b11, 8'd0);
      tick();
      we_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         drive(i % 2 == 0, 2'b10, 8'(8'h40 + i / 2));
         tick();
      end
      drive(0, 2'b00, '0);
      tick();
      chk("load16_writes", we_cnt, 16);
      chk("load16_state", state, 0);

      // Three single steps
      for (int k = 0; k < 3; k++) begin
         drive(1, 2'b01, '0);
         tick();
         drive(0, 2'b00, '0);
         #1;
         chk("step_ready_low", cmd_ready, 0);
         chk("step_en_high", core_en, 1);
         tick();
         tick();
      end
      chk("step_icount", icount, 3);

      // Breakpoint at pc=5 then resume from it
      do_reset();
      bp_en = 1; bp_addr = 4'd5; bp_cnt = 0;
      drive(1, 2'b00, '0);
      tick();
      drive(0, 2'b00, '0);
      for (int i = 0; i < 8; i++) tick();
      chk("bp_icount", icount, 5);
      chk("bp_state", state, 0);
      chk("bp_pulses", bp_cnt, 1);
      drive(1, 2'b00, '0);
      tick();
      drive(0, 2'b00, '0);
      tick();
      tick();
      drive(1, 2'b10, '0);
      tick();
      drive(0, 2'b00, '0);
      tick();
      chk("bp_resume_icount", icount, 8);
      chk("bp_resume_state", state, 0);

      // HALT at pc=2, then reset in the middle of a later run
      do_reset();
      bp_en = 0;
      drive(1, 2'b00, '0);
      tick();
      drive(0, 2'b00, '0);
      tick();
      tick();
      drive(1, 2'b10, '0);
      tick();
      chk("halt_state", state, 0);
      chk("halt_icount", icount, 3);
      drive(1, 2'b00, '0);
      tick();
      drive(0, 2'b00, '0);
      tick();
      tick();
      rst_n = 0;
      tick();
      chk("midrun_rst_state", state, 0);
      chk("midrun_rst_icount", icount, 0);
      chk("midrun_rst_start", core_start, 1);
      chk("midrun_rst_ready", cmd_ready, 0);
      rst_n = 1;

      // Saturation of the narrow counter
      drive(1, 2'b00, '0);
      tick();
      drive(0, 2'b00, '0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_icount16", icount, 20);
      chk("sat_icount4", s_icount, 15);
      drive(1, 2'b10, '0);
      tick();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_n     = ($urandom_range(0, 59) != 0);
         cmd_valid = $urandom_range(0, 1);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_data  = (m_state == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
         bp_en     = $urandom_range(0, 1);
         bp_addr   = 4'($urandom_range(0, DEPTH - 1));
         tick();
      end
      rst_n = 1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
